// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: width helper, status bundle for
// wrappers, and the minimum legal depth.
package fifo_pkg;

    localparam int unsigned FIFO_MIN_DEPTH = 2;

    // Address width that never collapses to zero bits for tiny memories.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// FIFO storage: DEPTH x DATA_W, synchronous write, asynchronous read, no reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AW     = clog2_min1(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : fifo_ram

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO of arbitrary depth with programmable almost-full/empty
// thresholds, occupancy output, sticky error flags and selectable read mode.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 8,
    parameter bit          SHOW_AHEAD = 1'b1,
    parameter int unsigned LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] data_push,
    input  logic              pop,
    output logic [DATA_W-1:0] data_pop,
    output logic              pop_valid,
    input  logic [LVL_W-1:0]  af_thresh,
    input  logic [LVL_W-1:0]  ae_thresh,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int unsigned     AW       = clog2_min1(DEPTH);
    localparam logic [AW-1:0]   PTR_LAST = AW'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_full;
    logic              r_empty;
    logic              r_almost_full;
    logic              r_almost_empty;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_pop_acc;
    logic              w_push_acc;
    logic [AW-1:0]     w_wr_ptr_nxt;
    logic [AW-1:0]     w_rd_ptr_nxt;
    logic [LVL_W-1:0]  w_level_nxt;
    logic [DATA_W-1:0] w_rdata;

    // A pop on empty is never satisfied by a same-cycle push.
    assign w_pop_acc  = pop & ~r_empty;
    assign w_push_acc = push & (~r_full | w_pop_acc);

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_level_nxt  = r_level;
        if (w_push_acc) begin
            w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + AW'(1);
        end
        if (w_pop_acc) begin
            w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + AW'(1);
        end
        case ({w_push_acc, w_pop_acc})
            2'b10:   w_level_nxt = r_level + LVL_W'(1);
            2'b01:   w_level_nxt = r_level - LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Flags derive from next-state level so they always agree with level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_level        <= w_level_nxt;
            r_full         <= (w_level_nxt == LVL_FULL);
            r_empty        <= (w_level_nxt == '0);
            r_almost_full  <= (w_level_nxt >= af_thresh);
            r_almost_empty <= (w_level_nxt <= ae_thresh);
            // Set takes priority over clear.
            if (push & ~w_push_acc) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (pop & r_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_push),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    if (SHOW_AHEAD) begin : g_show_ahead
        assign data_pop  = w_rdata;
        assign pop_valid = ~r_empty;
    end else begin : g_reg_read
        logic [DATA_W-1:0] r_data_pop;
        logic              r_pop_valid;

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_data_pop  <= '0;
                r_pop_valid <= 1'b0;
            end else begin
                r_pop_valid <= w_pop_acc;
                if (w_pop_acc) begin
                    r_data_pop <= w_rdata;
                end
            end
        end

        assign data_pop  = r_data_pop;
        assign pop_valid = r_pop_valid;
    end

    assign level        = r_level;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule : sync_fifo_prog

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: a show-ahead and a registered-read
// instance (DEPTH=5) driven by the same stimulus.
module tb_sync_fifo_prog;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 5;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic [DW-1:0] data_push;
    logic          pop;
    logic [LW-1:0] af_thresh;
    logic [LW-1:0] ae_thresh;
    logic          err_clr;

    logic [DW-1:0] a_data_pop, b_data_pop;
    logic          a_pop_valid, b_pop_valid;
    logic [LW-1:0] a_level, b_level;
    logic          a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic          b_full, b_empty, b_af, b_ae, b_ovf, b_unf;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_W(DW), .DEPTH(DEPTH), .SHOW_AHEAD(1'b1)) u_sa1 (
        .clk(clk), .rst(rst), .push(push), .data_push(data_push), .pop(pop),
        .data_pop(a_data_pop), .pop_valid(a_pop_valid),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .level(a_level),
        .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
        .overflow(a_ovf), .underflow(a_unf), .err_clr(err_clr)
    );

    sync_fifo_prog #(.DATA_W(DW), .DEPTH(DEPTH), .SHOW_AHEAD(1'b0)) u_sa0 (
        .clk(clk), .rst(rst), .push(push), .data_push(data_push), .pop(pop),
        .data_pop(b_data_pop), .pop_valid(b_pop_valid),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .level(b_level),
        .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .overflow(b_ovf), .underflow(b_unf), .err_clr(err_clr)
    );

    // Threshold legality while out of reset.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            assert (af_thresh >= 1 && af_thresh <= LW'(DEPTH))
                else $error("af_thresh out of range: %0d", af_thresh);
            assert (ae_thresh <= LW'(DEPTH - 1))
                else $error("ae_thresh out of range: %0d", ae_thresh);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [DW-1:0] d);
        push = 1'b1; data_push = d; pop = 1'b0;
        tick();
        push = 1'b0;
    endtask

    // Pop one word, checking both read modes against the expected value.
    task automatic do_pop(input string tag, input logic [DW-1:0] d);
        chk({tag, "_sa1_data"}, 32'(a_data_pop), 32'(d));
        pop = 1'b1; push = 1'b0;
        tick();
        pop = 1'b0;
        chk({tag, "_sa0_valid"}, 32'(b_pop_valid), 32'd1);
        chk({tag, "_sa0_data"}, 32'(b_data_pop), 32'(d));
    endtask

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; data_push = '0;
        af_thresh = LW'(4); ae_thresh = LW'(1); err_clr = 1'b0;
        tick(); tick();
        rst = 1'b1;

        // Reset state
        chk("rst_level", 32'(a_level), 32'd0);
        chk("rst_empty", 32'(a_empty), 32'd1);
        chk("rst_ae",    32'(a_ae),    32'd1);
        chk("rst_full",  32'(a_full),  32'd0);
        chk("rst_af",    32'(a_af),    32'd0);
        chk("rst_ovf",   32'(a_ovf),   32'd0);
        chk("rst_unf",   32'(a_unf),   32'd0);
        chk("rst_sa1_valid", 32'(a_pop_valid), 32'd0);
        chk("rst_sa0_valid", 32'(b_pop_valid), 32'd0);
        chk("rst_sa0_data",  32'(b_data_pop),  32'd0);

        // Test 1: fill 0x11..0x15, then drain in order
        do_push(8'h11);
        chk("t1_lvl1", 32'(a_level), 32'd1); chk("t1_ae1", 32'(a_ae), 32'd1);
        chk("t1_valid1", 32'(a_pop_valid), 32'd1);
        do_push(8'h12);
        chk("t1_lvl2", 32'(a_level), 32'd2); chk("t1_ae2", 32'(a_ae), 32'd0);
        do_push(8'h13);
        chk("t1_lvl3", 32'(a_level), 32'd3); chk("t1_af3", 32'(a_af), 32'd0);
        do_push(8'h14);
        chk("t1_lvl4", 32'(a_level), 32'd4); chk("t1_af4", 32'(a_af), 32'd1);
        chk("t1_full4", 32'(a_full), 32'd0);
        do_push(8'h15);
        chk("t1_lvl5", 32'(a_level), 32'd5); chk("t1_full5", 32'(a_full), 32'd1);
        chk("t1_sa0_lvl5", 32'(b_level), 32'd5);
        do_pop("t1_p1", 8'h11);
        chk("t1_full_drop", 32'(a_full), 32'd0);
        do_pop("t1_p2", 8'h12);
        do_pop("t1_p3", 8'h13);
        do_pop("t1_p4", 8'h14);
        do_pop("t1_p5", 8'h15);
        chk("t1_empty", 32'(a_empty), 32'd1);
        chk("t1_lvl0", 32'(a_level), 32'd0);
        tick();
        chk("t1_sa0_valid_idle", 32'(b_pop_valid), 32'd0);
        chk("t1_sa0_data_hold", 32'(b_data_pop), 32'h15);

        // Test 2: pointer wrap
        do_push(8'h31); do_push(8'h32); do_push(8'h33);
        do_pop("t2_a", 8'h31); do_pop("t2_b", 8'h32); do_pop("t2_c", 8'h33);
        for (int i = 0; i < 5; i++) do_push(8'hA0 + 8'(i));
        chk("t2_lvl5", 32'(a_level), 32'd5);
        do_pop("t2_w0", 8'hA0); do_pop("t2_w1", 8'hA1); do_pop("t2_w2", 8'hA2);
        do_pop("t2_w3", 8'hA3); do_pop("t2_w4", 8'hA4);
        chk("t2_lvl0", 32'(a_level), 32'd0);

        // Test 3: overflow and err_clr priority
        for (int i = 0; i < 5; i++) do_push(8'h51 + 8'(i));
        do_push(8'hEE);
        chk("t3_ovf_set", 32'(a_ovf), 32'd1);
        chk("t3_lvl", 32'(a_level), 32'd5);
        err_clr = 1'b1; tick();
        chk("t3_ovf_clr", 32'(a_ovf), 32'd0);
        push = 1'b1; data_push = 8'hEF; tick(); push = 1'b0; err_clr = 1'b0;
        chk("t3_ovf_setwins", 32'(a_ovf), 32'd1);

        // Test 4: simultaneous push/pop on full, then on empty
        chk("t4_head", 32'(a_data_pop), 32'h51);
        push = 1'b1; pop = 1'b1; data_push = 8'h66; tick();
        push = 1'b0; pop = 1'b0;
        chk("t4_lvl_full", 32'(a_level), 32'd5);
        chk("t4_sa0_data", 32'(b_data_pop), 32'h51);
        do_pop("t4_d1", 8'h52); do_pop("t4_d2", 8'h53); do_pop("t4_d3", 8'h54);
        do_pop("t4_d4", 8'h55); do_pop("t4_d5", 8'h66);
        push = 1'b1; pop = 1'b1; data_push = 8'h77; tick();
        push = 1'b0; pop = 1'b0;
        chk("t4_lvl1", 32'(a_level), 32'd1);
        chk("t4_unf", 32'(a_unf), 32'd1);
        chk("t4_sa0_novalid", 32'(b_pop_valid), 32'd0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t4_clr_ovf", 32'(a_ovf), 32'd0);
        chk("t4_clr_unf", 32'(a_unf), 32'd0);

        // Test 5: threshold change without traffic
        do_push(8'h78); do_push(8'h79);
        chk("t5_lvl3", 32'(a_level), 32'd3);
        chk("t5_af_before", 32'(a_af), 32'd0);
        chk("t5_ae_before", 32'(a_ae), 32'd0);
        af_thresh = LW'(3); tick();
        chk("t5_af_after", 32'(a_af), 32'd1);
        ae_thresh = LW'(3); tick();
        chk("t5_ae_after", 32'(a_ae), 32'd1);
        af_thresh = LW'(4); ae_thresh = LW'(1); tick();
        chk("t5_af_restore", 32'(a_af), 32'd0);

        // Test 6: registered read and mid-operation reset
        do_pop("t6_d1", 8'h77); do_pop("t6_d2", 8'h78); do_pop("t6_d3", 8'h79);
        pop = 1'b1; tick(); pop = 1'b0;
        chk("t6_unf", 32'(b_unf), 32'd1);
        do_push(8'h21); do_push(8'h22);
        pop = 1'b1; tick(); pop = 1'b0;
        chk("t6_valid", 32'(b_pop_valid), 32'd1);
        chk("t6_data", 32'(b_data_pop), 32'h21);
        chk("t6_lvl1", 32'(b_level), 32'd1);
        rst = 1'b0; tick(); rst = 1'b1;
        chk("t6_rst_lvl", 32'(b_level), 32'd0);
        chk("t6_rst_empty", 32'(b_empty), 32'd1);
        chk("t6_rst_valid", 32'(b_pop_valid), 32'd0);
        chk("t6_rst_data", 32'(b_data_pop), 32'd0);
        chk("t6_rst_unf", 32'(b_unf), 32'd0);
        chk("t6_rst_ovf", 32'(b_ovf), 32'd0);
        chk("t6_sa1_rst_lvl", 32'(a_level), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_sync_fifo_prog
